instruction_fetch_queue: RTL and testbench

Front-end fetch stage that owns the fetch PC, issues instruction reads to the cache and buffers returned instructions with their PCs in a small FIFO. The FIFO decouples cache latency from the decode pipeline. It feeds the branch-prediction/decode register on the downstream side. A redirect from branch prediction or recovery flushes the FIFO and restarts fetch at a new PC.

---
 rtl/instruction_fetch_queue.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
// Front-end fetch stage. Owns the fetch PC, issues reads to the instruction
// cache and buffers returned {instruction, pc} pairs in a small FIFO that
// feeds decode. A redirect flushes the FIFO and restarts fetch at a new PC.
//
// Ports
//   clk                  single clock, rising edge
//   reset                asynchronous active-high reset
//   entry                program entry point, loaded into the fetch PC by reset
//   instruction_address  current fetch PC to the cache
//   instruction_read     fetch request to the cache
//   instruction_busy     cache still working on the request
//   instruction_response instruction for instruction_address
//   redirect             flush FIFO and restart fetch at redirect_pc
//   redirect_pc          new fetch PC
//   out_ready            downstream accepts the head entry
//   out_valid            FIFO head valid
//   out_instruction      head instruction
//   out_pc               head PC
//   count                FIFO occupancy 0..DEPTH
//   full / empty         count==DEPTH / count==0
//
// State | Meaning
//   S_FETCH   | requesting instructions while the FIFO has room
//   S_HOLD    | FIFO filled by an accept; no requests until room appears
//   S_RESTART | one idle cycle after a redirect so the cache sees a new request
module instruction_fetch_queue #(
  parameter int DEPTH            = 4,
  parameter int ADDRESS_SIZE     = 64,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESS_SIZE-1:0]     entry,
  output logic [ADDRESS_SIZE-1:0]     instruction_address,
  output logic                        instruction_read,
  input  logic                        instruction_busy,
  input  logic [INSTRUCTION_SIZE-1:0] instruction_response,
  input  logic                        redirect,
  input  logic [ADDRESS_SIZE-1:0]     redirect_pc,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic [ADDRESS_SIZE-1:0]     out_pc,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_RESTART
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [PW-1:0]               r_head;
  logic [PW-1:0]               r_tail;
  logic [CW-1:0]               r_count;
  logic [CW-1:0]               w_count_next;
  logic [ADDRESS_SIZE-1:0]     r_pc;
  logic [INSTRUCTION_SIZE-1:0] r_mem_instr [DEPTH];
  logic [ADDRESS_SIZE-1:0]     r_mem_pc    [DEPTH];
  logic                        w_read;
  logic                        w_accept;
  logic                        w_pop;

  assign w_accept = w_read && !instruction_busy && !redirect;
  assign w_pop    = (r_count != '0) && out_ready && !redirect;

  always_comb begin
    w_count_next = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Read request is masked while reset is held so the cache never sees a
  // request from the reset-loaded state.
  always_comb begin
    w_state_next = r_state;
    w_read       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_read = !reset && (r_count < L_DEPTH);
        if (w_accept && (w_count_next == L_DEPTH)) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (r_count < L_DEPTH) w_state_next = S_FETCH;
      end
      S_RESTART: begin
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
    if (redirect) w_state_next = S_RESTART;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= entry;
    end else if (redirect) begin
      r_state <= w_state_next;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= redirect_pc;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_tail <= r_tail + PW'(1);
        r_pc   <= r_pc + ADDRESS_SIZE'(4);
      end
      if (w_pop) r_head <= r_head + PW'(1);
    end
  end

  // Storage needs no reset: validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_instr[r_tail] <= instruction_response;
      r_mem_pc[r_tail]    <= r_pc;
    end
  end

  assign instruction_address = r_pc;
  assign instruction_read    = w_read;
  assign out_valid           = (r_count != '0);
  assign out_instruction     = r_mem_instr[r_head];
  assign out_pc              = r_mem_pc[r_head];
  assign count               = r_count;
  assign full                = (r_count == L_DEPTH);
  assign empty               = (r_count == '0);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] entry = '0;
  logic [AW-1:0] instruction_address;
  logic          instruction_read;
  logic          busy = 1'b0;
  logic [IW-1:0] instruction_response;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_instruction;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  instruction_fetch_queue #(
    .DEPTH(DEPTH), .ADDRESS_SIZE(AW), .INSTRUCTION_SIZE(IW)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .instruction_address(instruction_address),
    .instruction_read(instruction_read),
    .instruction_busy(busy),
    .instruction_response(instruction_response),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Cache model: the instruction is a fixed function of its address; a busy
  // cache drives garbage so a wrongly timed enqueue is visible.
  function automatic logic [IW-1:0] resp(input logic [AW-1:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  assign instruction_response = busy ? 32'hDEAD_BEEF : resp(instruction_address);

  // Reference model: queue of buffered PCs, fetch PC, and two flags for the
  // idle cycle after a redirect and for the stall after filling up.
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_pc;
  bit            m_restart;
  bit            m_hold;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic bit m_read();
    return !m_restart && !m_hold && (m_q.size() < DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_model();
    chk("read", 64'(instruction_read), 64'(m_read()));
    chk("addr", instruction_address, m_pc);
    chk("valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0]);
      chk("out_instr", 64'(out_instruction), 64'(resp(m_q[0])));
    end
    chk("count", 64'(count), 64'(m_q.size()));
    chk("full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(m_q.size() == 0));
  endtask

  // Called at a falling edge: apply inputs, then check settled outputs.
  task automatic drive(input bit b, input bit rdy, input bit rd, input logic [AW-1:0] rpc);
    busy = b; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    check_model();
  endtask

  task automatic advance();
    bit rd_e, acc, pop;
    int sz0;
    rd_e = m_read();
    sz0  = m_q.size();
    @(posedge clk);
    if (redirect) begin
      m_q.delete();
      m_pc      = redirect_pc;
      m_restart = 1'b1;
      m_hold    = 1'b0;
    end else begin
      acc = rd_e && !busy;
      pop = (sz0 > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
      m_restart = 1'b0;
      m_hold    = m_hold ? (sz0 == DEPTH) : (acc && m_q.size() == DEPTH);
    end
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle, checked before any clock edge, released at a falling edge.
  task automatic do_reset(input logic [AW-1:0] e);
    entry = e; busy = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_read", 64'(instruction_read), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_addr", instruction_address, e);
    m_q.delete();
    m_pc = e; m_restart = 1'b0; m_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit            b;
    bit            rdy;
    bit            rd;
    logic [AW-1:0] rpc;
    bit            e_read;
    logic [AW-1:0] e_addr;
    bit            e_valid;
    logic [AW-1:0] e_pc;
    int            e_count;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // busy rdy redir rpc | read addr valid pc count
    tbl[0]  = '{0, 1, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    0};
    tbl[1]  = '{0, 1, 0, 64'h0,    1, 64'h1004, 1, 64'h1000, 1};
    tbl[2]  = '{0, 1, 0, 64'h0,    1, 64'h1008, 1, 64'h1004, 1};
    tbl[3]  = '{1, 1, 0, 64'h0,    1, 64'h100C, 1, 64'h1008, 1};
    tbl[4]  = '{1, 1, 0, 64'h0,    1, 64'h100C, 0, 64'h0,    0};
    tbl[5]  = '{1, 1, 0, 64'h0,    1, 64'h100C, 0, 64'h0,    0};
    tbl[6]  = '{0, 0, 0, 64'h0,    1, 64'h100C, 0, 64'h0,    0};
    tbl[7]  = '{0, 0, 0, 64'h0,    1, 64'h1010, 1, 64'h100C, 1};
    tbl[8]  = '{0, 0, 0, 64'h0,    1, 64'h1014, 1, 64'h100C, 2};
    tbl[9]  = '{0, 0, 0, 64'h0,    1, 64'h1018, 1, 64'h100C, 3};
    tbl[10] = '{0, 1, 0, 64'h0,    0, 64'h101C, 1, 64'h100C, 4};
    tbl[11] = '{0, 0, 0, 64'h0,    0, 64'h101C, 1, 64'h1010, 3};
    tbl[12] = '{0, 0, 0, 64'h0,    1, 64'h101C, 1, 64'h1010, 3};
    tbl[13] = '{0, 0, 0, 64'h0,    0, 64'h1020, 1, 64'h1010, 4};
    tbl[14] = '{0, 1, 0, 64'h0,    0, 64'h1020, 1, 64'h1010, 4};
    tbl[15] = '{0, 0, 0, 64'h0,    0, 64'h1020, 1, 64'h1014, 3};
    tbl[16] = '{0, 1, 1, 64'h2000, 1, 64'h1020, 1, 64'h1014, 3};
    tbl[17] = '{0, 1, 0, 64'h0,    0, 64'h2000, 0, 64'h0,    0};
    tbl[18] = '{0, 1, 0, 64'h0,    1, 64'h2000, 0, 64'h0,    0};
    tbl[19] = '{0, 1, 0, 64'h0,    1, 64'h2004, 1, 64'h2000, 1};

    do_reset(64'h1000);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].b, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("t%0d_read", i), 64'(instruction_read), 64'(tbl[i].e_read));
      chk($sformatf("t%0d_addr", i), instruction_address, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("t%0d_count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("t%0d_full", i), 64'(full), 64'(tbl[i].e_count == DEPTH));
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_instr", i), 64'(out_instruction), 64'(resp(tbl[i].e_pc)));
      end
      advance();
    end

    // PC wrap at the top of the address space.
    drive(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8); advance();
    drive(0, 1, 0, 64'h0); advance();
    drive(0, 1, 0, 64'h0); advance();
    drive(0, 1, 0, 64'h0); advance();
    drive(0, 1, 0, 64'h0);
    chk("wrap_addr", instruction_address, 64'h0);
    chk("wrap_head", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();

    // Async reset with two entries buffered.
    drive(0, 0, 1, 64'h3000); advance();
    drive(0, 0, 0, 64'h0);    advance();
    drive(0, 0, 0, 64'h0);    advance();
    drive(0, 0, 0, 64'h0);    advance();
    drive(1, 0, 0, 64'h0);
    chk("pre_rst_count", 64'(count), 64'd2);
    do_reset(64'h4000);
    drive(0, 1, 0, 64'h0);
    chk("post_rst_addr", instruction_address, 64'h4000);
    advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        do_reset({$urandom, $urandom} & ~64'h3);
      end else begin
        logic [AW-1:0] rpc;
        if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(3));
        else rpc = {$urandom, $urandom} & ~64'h3;
        drive($urandom_range(2) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0, rpc);
        advance();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
